word_clip_axil_regs: RTL and testbench

//  AXI4-Lite responder holding the word clipper's control/config registers. Accepts single-beat

---
 rtl/word_clip_axil_regs.sv | 155 +++++++++++++++
 tb/tb_word_clip_axil_regs.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/word_clip_axil_regs.sv
// AXI4-Lite responder holding the word clipper's control/config registers.
// AW and W are captured independently; one write and one read may be outstanding at once.
module word_clip_axil_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(NUM_REGS);

  logic                  r_aw_held;
  logic [IDX_W-1:0]      r_aw_idx;
  logic                  r_w_held;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_W-1:0]     r_w_strb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_awready, w_wready, w_arready;
  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [IDX_W-1:0]      w_widx, w_ridx;
  logic                  w_widx_ok, w_ridx_ok;
  logic [DATA_WIDTH-1:0] w_wdata, w_rsel;
  logic [STRB_W-1:0]     w_wstrb;
  logic                  w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_awready = !r_aw_held && !r_bvalid;
  assign w_wready  = !r_w_held && !r_bvalid;
  assign w_arready = !r_rvalid;
  assign w_aw_hs   = S_AXI_AWVALID && w_awready;
  assign w_w_hs    = S_AXI_WVALID && w_wready;
  assign w_ar_hs   = S_AXI_ARVALID && w_arready;
  // Commit as soon as both halves are available, whether held or arriving this edge.
  assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

  assign w_widx    = r_aw_held ? r_aw_idx : S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign w_wdata   = r_w_held ? r_w_data : S_AXI_WDATA;
  assign w_wstrb   = r_w_held ? r_w_strb : S_AXI_WSTRB;
  assign w_ridx    = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign w_widx_ok = {1'b0, w_widx} < NUM_REGS_L;
  assign w_ridx_ok = {1'b0, w_ridx} < NUM_REGS_L;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      if (w_commit)     r_aw_held <= 1'b0;
      else if (w_aw_hs) r_aw_held <= 1'b1;
      if (w_aw_hs)      r_aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      if (w_commit)     r_w_held  <= 1'b0;
      else if (w_w_hs)  r_w_held  <= 1'b1;
      if (w_w_hs) begin
        r_w_data <= S_AXI_WDATA;
        r_w_strb <= S_AXI_WSTRB;
      end
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_widx_ok ? 2'b00 : 2'b10;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rsel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ridx == IDX_W'(i)) w_rsel = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ridx_ok ? w_rsel : '0;
      r_rresp  <= w_ridx_ok ? 2'b00 : 2'b10;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_WIDTH-1:0] r_q;
    logic                  r_pulse;
    logic                  w_sel;

    assign w_sel = w_commit && (w_widx == IDX_W'(gi));

    always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
        r_q     <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= w_sel;
        if (w_sel) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_wstrb[b]) r_q[b*8 +: 8] <= w_wdata[b*8 +: 8];
          end
        end
      end
    end

    assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = r_q;
    assign reg_wr_pulse[gi] = r_pulse;
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
endmodule

// File: tb/tb_word_clip_axil_regs.sv
// Directed + randomized bench for word_clip_axil_regs (ADDR_WIDTH=5 so 0x10..0x1F are unmapped).
// Reference model is a plain register array updated byte-wise by strobes.
module tb_word_clip_axil_regs;
  localparam int NREG = 4;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [4:0]   S_AXI_AWADDR = '0;
  logic [2:0]   S_AXI_AWPROT = '0;
  logic         S_AXI_AWVALID = 1'b0;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA = '0;
  logic [3:0]   S_AXI_WSTRB = '0;
  logic         S_AXI_WVALID = 1'b0;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY = 1'b0;
  logic [4:0]   S_AXI_ARADDR = '0;
  logic [2:0]   S_AXI_ARPROT = '0;
  logic         S_AXI_ARVALID = 1'b0;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY = 1'b0;
  logic [127:0] reg_q;
  logic [3:0]   reg_wr_pulse;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] m [NREG];

  word_clip_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(NREG)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: obs=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] m_flat();
    return {m[3], m[2], m[1], m[0]};
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    int idx = int'(a[4:2]);
    return (idx < NREG) ? m[idx] : 32'h0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NREG; i++) m[i] = 32'h0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, input int brd);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_fire, w_fire;
    int c = 0;
    int idx = int'(a[4:2]);
    logic [1:0] exp_resp = (idx < NREG) ? 2'b00 : 2'b10;
    logic [3:0] exp_pulse = (idx < NREG) ? 4'(1 << idx) : 4'b0;
    while (!(aw_done && w_done) && c < 50) begin
      @(negedge ACLK);
      S_AXI_AWADDR  = a;
      S_AXI_WDATA   = d;
      S_AXI_WSTRB   = s;
      S_AXI_AWVALID = !aw_done && (c >= awd);
      S_AXI_WVALID  = !w_done && (c >= wd);
      #1;
      if (aw_done) check("awready_while_held", S_AXI_AWREADY, 1'b0);
      if (w_done)  check("wready_while_held", S_AXI_WREADY, 1'b0);
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK);
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      c++;
    end
    check("write_accepted", {aw_done, w_done}, 2'b11);
    if (idx < NREG)
      for (int b = 0; b < 4; b++) if (s[b]) m[idx][b*8 +: 8] = d[b*8 +: 8];
    for (int k = 0; k <= brd; k++) begin
      @(negedge ACLK);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      check("bvalid", S_AXI_BVALID, 1'b1);
      check("bresp", S_AXI_BRESP, exp_resp);
      check("awready_during_b", S_AXI_AWREADY, 1'b0);
      check("wready_during_b", S_AXI_WREADY, 1'b0);
      check("wr_pulse", reg_wr_pulse, (k == 0) ? exp_pulse : 4'b0);
      if (k == brd) S_AXI_BREADY = 1'b1;
      @(posedge ACLK);
    end
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    check("bvalid_cleared", S_AXI_BVALID, 1'b0);
    check("wr_pulse_cleared", reg_wr_pulse, 4'b0);
    check("reg_q", reg_q, m_flat());
    $display("WR addr=%02h data=%08h strb=%h awd=%0d wd=%0d brd=%0d resp=%b",
             a, d, s, awd, wd, brd, exp_resp);
  endtask

  task automatic do_read(input logic [4:0] a, input int rrd,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    @(negedge ACLK);
    S_AXI_ARADDR  = a;
    S_AXI_ARVALID = 1'b1;
    #1;
    check("arready", S_AXI_ARREADY, 1'b1);
    @(posedge ACLK);
    for (int k = 0; k <= rrd; k++) begin
      @(negedge ACLK);
      S_AXI_ARVALID = 1'b0;
      check("rvalid", S_AXI_RVALID, 1'b1);
      check("rdata", S_AXI_RDATA, exp_data);
      check("rresp", S_AXI_RRESP, exp_resp);
      check("arready_during_r", S_AXI_ARREADY, 1'b0);
      if (k == rrd) S_AXI_RREADY = 1'b1;
      @(posedge ACLK);
    end
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    check("rvalid_cleared", S_AXI_RVALID, 1'b0);
    $display("RD addr=%02h data=%08h resp=%b rrd=%0d", a, exp_data, exp_resp, rrd);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_awready"}, S_AXI_AWREADY, 1'b1);
    check({tag, "_wready"},  S_AXI_WREADY, 1'b1);
    check({tag, "_arready"}, S_AXI_ARREADY, 1'b1);
    check({tag, "_bvalid"},  S_AXI_BVALID, 1'b0);
    check({tag, "_rvalid"},  S_AXI_RVALID, 1'b0);
    check({tag, "_reg_q"},   reg_q, 128'h0);
    check({tag, "_pulse"},   reg_wr_pulse, 4'b0);
  endtask

  function automatic logic [1:0] m_resp(input logic [4:0] a);
    return (int'(a[4:2]) < NREG) ? 2'b00 : 2'b10;
  endfunction

  initial begin
    logic [4:0]  ra;
    logic [31:0] rd_exp;
    m_clear();
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    check_idle("reset");
    check("reset_bresp", S_AXI_BRESP, 2'b00);
    check("reset_rresp", S_AXI_RRESP, 2'b00);
    check("reset_rdata", S_AXI_RDATA, 32'h0);

    for (int i = 0; i < 4; i++) do_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(5'(4 * i), 0, m_rd(5'(4 * i)), 2'b00);

    do_write(5'h00, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(5'h00, 32'h11223344, 4'b0101, 0, 0, 0);
    do_read(5'h00, 0, m_rd(5'h00), 2'b00);

    do_write(5'h04, 32'hCAFEF00D, 4'hF, 3, 0, 0);
    do_write(5'h08, 32'h0BADBEEF, 4'hF, 0, 2, 0);
    do_write(5'h0C, 32'h12345678, 4'b1010, 0, 0, 5);
    do_write(5'h0E, 32'h87654321, 4'hF, 0, 0, 0);

    do_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(5'h1C, 32'h55555555, 4'hF, 1, 0, 2);
    do_read(5'h10, 0, 32'h0, 2'b10);
    do_read(5'h15, 3, 32'h0, 2'b10);

    rd_exp = m_rd(5'h04);
    fork
      do_write(5'h04, 32'hDEADDEAD, 4'hF, 0, 0, 0);
      do_read(5'h04, 0, rd_exp, 2'b00);
    join

    for (int t = 0; t < 40; t++) begin
      logic [4:0]  wa;
      logic [31:0] wdat;
      wa   = 5'($urandom_range(0, 31));
      wdat = $urandom;
      do_write(wa, wdat, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 2));
      ra = 5'($urandom_range(0, 31));
      do_read(ra, $urandom_range(0, 2), m_rd(ra), m_resp(ra));
    end

    @(negedge ACLK);
    S_AXI_AWADDR  = 5'h04;
    S_AXI_AWVALID = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    check("aw_held_before_reset", S_AXI_AWREADY, 1'b0);
    #2 ARESET = 1'b1;
    #1 check("async_reset_reg_q", reg_q, 128'h0);
    m_clear();
    @(negedge ACLK);
    ARESET = 1'b0;
    check_idle("midreset");
    S_AXI_WDATA  = 32'h13579BDF;
    S_AXI_WSTRB  = 4'hF;
    S_AXI_WVALID = 1'b1;
    @(posedge ACLK);
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      S_AXI_WVALID = 1'b0;
      check("no_stale_bvalid", S_AXI_BVALID, 1'b0);
      check("no_stale_update", reg_q, 128'h0);
    end
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    check_idle("reset2");
    do_write(5'h08, 32'h00C0FFEE, 4'hF, 0, 0, 0);
    do_read(5'h08, 0, m_rd(5'h08), 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
